// File: rtl/logic_op_arbiter.sv
// ---------------------------------------------------------------------------
// logic_op_arbiter
//
// Purpose:
//   Shares one registered bitwise logic unit among NREQ requesters. A
//   round-robin arbiter picks one valid requester per cycle whenever the
//   single-entry result register can take a new value. The accepted operation
//   is evaluated and registered together with the requester index.
//
// Handshake rule (both sides):
//   A transfer happens at a rising clock edge where valid and ready are both
//   1. A producer holds valid and its payload stable until the transfer.
//   Ready never depends on the same side's payload, only on valid and on
//   the arbiter state.
//
// Optional feature:
//   LOGIC_ARB_OPSEL_EN - when defined, req_op selects the operation
//   (00 AND, 01 OR, 10 XOR, 11 NAND). When undefined, the operation is
//   always AND and req_op is ignored. The port list is the same either way.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NREQ        per-requester valid
//   req_ready  out  NREQ        per-requester grant (one-hot or zero)
//   req_a      in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand b, same packing
//   req_op     in   NREQ*2      op code, requester i at [i*2 +: 2]
//   res_valid  out  1           result register holds an unconsumed result
//   res_ready  in   1           consumer accepts the result
//   res_data   out  WIDTH       registered result
//   res_id     out  IDW         index of the requester that produced res_data
// ---------------------------------------------------------------------------
module logic_op_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id
);

    // IDLE: result register empty. FULL: result register holds a result.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e             state_q,    state_d;
    logic [IDW-1:0]     ptr_q,      ptr_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0]     res_id_q,   res_id_d;

    logic               slot_free;
    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   op_result;

    // The result register can take a new value when it is empty or when the
    // current value is being consumed in this same cycle.
    assign slot_free = (state_q == IDLE) | res_ready;

    // Round-robin search: first valid requester at ptr, ptr+1, ... wrapping
    // modulo NREQ. ptr + k never exceeds 2*NREQ-2, so one subtraction wraps.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // A grant implies the matching valid bit, so a grant is an acceptance.
    // rst_n gates the grant so no requester sees ready while reset is held.
    assign accept = rst_n & slot_free & grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign a_sel = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(grant_idx)*WIDTH +: WIDTH];

`ifdef LOGIC_ARB_OPSEL_EN
    logic [1:0] op_sel;
    assign op_sel = req_op[int'(grant_idx)*2 +: 2];

    always_comb begin
        op_result = a_sel & b_sel;
        case (op_sel)
            2'b00:   op_result = a_sel & b_sel;
            2'b01:   op_result = a_sel | b_sel;
            2'b10:   op_result = a_sel ^ b_sel;
            2'b11:   op_result = ~(a_sel & b_sel);
            default: op_result = a_sel & b_sel;
        endcase
    end
`else
    // Operation fixed to AND; req_op is intentionally left unconnected.
    logic unused_req_op;
    assign unused_req_op = ^req_op;
    assign op_result     = a_sel & b_sel;
`endif

    // Next-state and register update.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        if (accept) begin
            // New result replaces any result consumed in this same cycle.
            state_d    = FULL;
            res_data_d = op_result;
            res_id_d   = grant_idx;
            ptr_d      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if ((state_q == FULL) && res_ready) begin
            // Consumed with nothing new: empty the slot, keep data and id.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule
